fft_peak_search: RTL and testbench

FFT_PEAK_SEARCH -- requirements
Module: fft_peak_search

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_abs_mag.sv | 26 ++
 rtl/fft_peak_search.sv | 123 ++++++++++++
 tb/tb_fft_peak_search.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT peak search block.
// Holds the default frame length, search floor and detection threshold,
// the magnitude width and the controller state encoding.
package fft_pkg;

    localparam int          FFT_LEN_DEF    = 1024;
    localparam int          MIN_BIN_DEF    = 3;
    localparam logic [16:0] MAG_THRESH_DEF = 17'd512;
    localparam int          MAG_W          = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAV  = 2'd1,
        ST_JUDGE = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/fft_abs_mag.sv
// Combinational L1 magnitude of one complex FFT bin: |re| + |im|.
// Ports:
//   data : [15:0] real, [31:16] imaginary, two's complement
//   mag  : unsigned magnitude, 0..65536
module fft_abs_mag
    import fft_pkg::*;
(
    input  logic [31:0]      data,
    output logic [MAG_W-1:0] mag
);

    logic signed [16:0] re_ext;
    logic signed [16:0] im_ext;
    logic [16:0]        re_abs;
    logic [16:0]        im_abs;

    // Sign-extend to 17 bits first so that -32768 negates to +32768.
    always_comb begin
        re_ext = {data[15], data[15:0]};
        im_ext = {data[31], data[31:16]};
        re_abs = re_ext[16] ? 17'(-re_ext) : 17'(re_ext);
        im_abs = im_ext[16] ? 17'(-im_ext) : 17'(im_ext);
        mag    = re_abs + im_abs;
    end

endmodule

// File: rtl/fft_peak_search.sv
// Scans one FFT frame per pass for the strongest bin inside the search
// window and reports its index and magnitude when the frame is well formed
// and the peak reaches the detection threshold.
// Ports:
//   sys_clk, sys_rstn           : clock, async active-low reset
//   s_fft_tdata/tvalid/tlast    : FFT bin stream (re in [15:0], im in [31:16])
//   s_fft_tready                : beat accepted when tvalid && tready
//   convert_freq_data           : index of the reported peak bin
//   convert_freq_valid          : one-cycle pulse qualifying a new report
//   sta_ram_trav                : high while a frame is being traversed
//   peak_mag                    : magnitude of the last reported peak
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for bin 0 of a frame, running max cleared
// ST_TRAV  | accepting bins, tracking running max and frame errors
// ST_JUDGE | frame closed, decide whether the peak is reportable
// ST_OUT   | report pulse cycle, clear search state for next frame
module fft_peak_search
    import fft_pkg::*;
#(
    parameter int          FFT_LEN    = FFT_LEN_DEF,
    parameter int          MIN_BIN    = MIN_BIN_DEF,
    parameter logic [16:0] MAG_THRESH = MAG_THRESH_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rstn,
    input  logic [31:0] s_fft_tdata,
    input  logic        s_fft_tvalid,
    input  logic        s_fft_tlast,
    output logic        s_fft_tready,
    output logic [15:0] convert_freq_data,
    output logic        convert_freq_valid,
    output logic        sta_ram_trav,
    output logic [16:0] peak_mag
);

    localparam int                CNT_W    = $clog2(FFT_LEN);
    localparam logic [CNT_W-1:0]  LO_BIN   = CNT_W'(MIN_BIN);
    localparam logic [CNT_W-1:0]  HI_BIN   = CNT_W'(FFT_LEN / 2 - 1);
    localparam logic [CNT_W-1:0]  LAST_BIN = CNT_W'(FFT_LEN - 1);

    state_t            state;
    logic [CNT_W-1:0]  bin_cnt;
    logic [MAG_W-1:0]  max_mag;
    logic [CNT_W-1:0]  max_idx;
    logic              frame_err;

    logic [MAG_W-1:0]  mag;
    logic              accept;
    logic              in_range;

    fft_abs_mag u_abs_mag (
        .data (s_fft_tdata),
        .mag  (mag)
    );

    // Gated by reset so the stream sees not-ready while held in reset and
    // ready as soon as reset releases.
    assign s_fft_tready = sys_rstn && ((state == ST_IDLE) || (state == ST_TRAV));
    assign accept       = s_fft_tvalid && s_fft_tready;
    assign in_range     = (bin_cnt >= LO_BIN) && (bin_cnt <= HI_BIN);

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state              <= ST_IDLE;
            bin_cnt            <= '0;
            max_mag            <= '0;
            max_idx            <= '0;
            frame_err          <= 1'b0;
            convert_freq_data  <= '0;
            convert_freq_valid <= 1'b0;
            sta_ram_trav       <= 1'b0;
            peak_mag           <= '0;
        end else begin
            convert_freq_valid <= 1'b0;
            case (state)
                // bin_cnt is zero in IDLE, so the first beat is bin 0 and
                // both states share the same per-beat handling.
                ST_IDLE, ST_TRAV: begin
                    if (accept) begin
                        bin_cnt <= bin_cnt + 1'b1;
                        if (in_range && (mag > max_mag)) begin
                            max_mag <= mag;
                            max_idx <= bin_cnt;
                        end
                        // tlast must coincide exactly with the final bin.
                        if (s_fft_tlast != (bin_cnt == LAST_BIN)) begin
                            frame_err <= 1'b1;
                        end
                        if (s_fft_tlast) begin
                            state        <= ST_JUDGE;
                            sta_ram_trav <= 1'b0;
                        end else begin
                            state        <= ST_TRAV;
                            sta_ram_trav <= 1'b1;
                        end
                    end
                end
                ST_JUDGE: begin
                    state <= ST_OUT;
                    if (!frame_err && (max_mag >= MAG_THRESH)) begin
                        convert_freq_valid <= 1'b1;
                        convert_freq_data  <= 16'(max_idx);
                        peak_mag           <= max_mag;
                    end
                end
                ST_OUT: begin
                    state     <= ST_IDLE;
                    bin_cnt   <= '0;
                    max_mag   <= '0;
                    max_idx   <= '0;
                    frame_err <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    sta_ram_trav <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_peak_search.sv
module tb_fft_peak_search;

    localparam int FFT_LEN = 1024;
    localparam int MIN_BIN = 3;
    localparam int THRESH  = 512;

    logic        sys_clk;
    logic        sys_rstn;
    logic [31:0] s_fft_tdata;
    logic        s_fft_tvalid;
    logic        s_fft_tlast;
    logic        s_fft_tready;
    logic [15:0] convert_freq_data;
    logic        convert_freq_valid;
    logic        sta_ram_trav;
    logic [16:0] peak_mag;

    fft_peak_search dut (
        .sys_clk            (sys_clk),
        .sys_rstn           (sys_rstn),
        .s_fft_tdata        (s_fft_tdata),
        .s_fft_tvalid       (s_fft_tvalid),
        .s_fft_tlast        (s_fft_tlast),
        .s_fft_tready       (s_fft_tready),
        .convert_freq_data  (convert_freq_data),
        .convert_freq_valid (convert_freq_valid),
        .sta_ram_trav       (sta_ram_trav),
        .peak_mag           (peak_mag)
    );

    typedef struct {
        int bin;
        int mag;
        int tcyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] fr[0:1099];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          last_bin = 0;
    int          last_mag = 0;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name, input longint act, input longint exp_v);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    function automatic logic [31:0] mk(input int re, input int im);
        logic [15:0] r;
        logic [15:0] i;
        r = 16'(re);
        i = 16'(im);
        return {i, r};
    endfunction

    function automatic int absmag(input logic [31:0] d);
        int re;
        int im;
        re = int'($signed(d[15:0]));
        im = int'($signed(d[31:16]));
        return (re < 0 ? -re : re) + (im < 0 ? -im : im);
    endfunction

    // Reference: a frame is good only if exactly FFT_LEN beats arrive with
    // tlast on the last one; the peak is the first strongest bin in the window.
    function automatic void model_frame(input int len, input int tcyc);
        int best = 0;
        int bidx = 0;
        for (int b = MIN_BIN; b < FFT_LEN / 2 && b < len; b++) begin
            if (absmag(fr[b]) > best) begin
                best = absmag(fr[b]);
                bidx = b;
            end
        end
        if (len == FFT_LEN && best >= THRESH) begin
            sb.push_back('{bidx, best, tcyc});
            last_bin = bidx;
            last_mag = best;
        end
    endfunction

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge sys_clk) begin
        if (sys_rstn && convert_freq_valid) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_pulse", convert_freq_data, -1);
            end else begin
                e = sb.pop_front();
                check(convert_freq_data == 16'(e.bin), "pulse_bin", convert_freq_data, e.bin);
                check(peak_mag == 17'(e.mag), "pulse_mag", peak_mag, e.mag);
                check(cyc == e.tcyc + 2, "pulse_latency", cyc, e.tcyc + 2);
                check(!sta_ram_trav, "valid_trav_overlap", sta_ram_trav, 0);
            end
        end
    end

    task automatic clear_frame();
        for (int b = 0; b < 1100; b++) fr[b] = 32'h0;
    endtask

    task automatic do_reset();
        s_fft_tvalid = 1'b0;
        s_fft_tlast  = 1'b0;
        @(negedge sys_clk);
        #1;
        sys_rstn = 1'b0;
        #1;
        check(!s_fft_tready, "rst_tready", s_fft_tready, 0);
        check(!convert_freq_valid, "rst_valid", convert_freq_valid, 0);
        check(!sta_ram_trav, "rst_trav", sta_ram_trav, 0);
        check(convert_freq_data == 16'd0, "rst_data", convert_freq_data, 0);
        check(peak_mag == 17'd0, "rst_mag", peak_mag, 0);
        sb.delete();
        last_bin = 0;
        last_mag = 0;
        repeat (2) @(posedge sys_clk);
        #2;
        sys_rstn = 1'b1;
        #1;
        check(s_fft_tready, "tready_after_release", s_fft_tready, 1);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic last, output int acc);
        acc = -1;
        s_fft_tdata  = d;
        s_fft_tvalid = 1'b1;
        s_fft_tlast  = last;
        for (int g = 0; g < 200; g++) begin
            @(negedge sys_clk);
            if (s_fft_tready) begin
                acc = cyc;
                @(posedge sys_clk);
                #1;
                return;
            end
            @(posedge sys_clk);
            #1;
        end
        check(1'b0, "beat_accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input int len, input int abort_at);
        int acc = 0;
        for (int k = 0; k < len; k++) begin
            if (k == abort_at) begin
                do_reset();
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                s_fft_tvalid = 1'b0;
                @(posedge sys_clk);
                #1;
            end
            drive_beat(fr[k], k == len - 1, acc);
            if (k == 0 && len > 1) begin
                check(sta_ram_trav && s_fft_tready, "trav_after_first", sta_ram_trav, 1);
            end
        end
        s_fft_tvalid = 1'b0;
        s_fft_tlast  = 1'b0;
        model_frame(len, acc);
        @(negedge sys_clk);
        check(!sta_ram_trav && !s_fft_tready, "judge_after_last", {sta_ram_trav, s_fft_tready}, 0);
        repeat (4) @(negedge sys_clk);
        check(convert_freq_data == 16'(last_bin), "held_data", convert_freq_data, last_bin);
        check(peak_mag == 17'(last_mag), "held_mag", peak_mag, last_mag);
        check(sb.size() == 0, "pulse_missing", sb.size(), 0);
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        sys_rstn     = 1'b0;
        s_fft_tdata  = 32'h0;
        s_fft_tvalid = 1'b0;
        s_fft_tlast  = 1'b0;
        do_reset();

        // Single peak with negative imaginary part.
        clear_frame();
        fr[100] = mk(3000, -4000);
        send_frame(FFT_LEN, -1);

        // Equal magnitudes: lowest bin wins.
        clear_frame();
        fr[50] = mk(1000, 1000);
        fr[80] = mk(-2000, 0);
        send_frame(FFT_LEN, -1);

        // Bin 1 is outside the window.
        clear_frame();
        fr[1]  = mk(9000, 0);
        fr[10] = mk(600, 0);
        send_frame(FFT_LEN, -1);
        clear_frame();
        fr[1]  = mk(9000, 0);
        fr[10] = mk(400, 0);
        send_frame(FFT_LEN, -1);

        // Window edges: bins 2 and 512 ignored, 511 accepted.
        clear_frame();
        fr[2]   = mk(20000, 0);
        fr[512] = mk(20000, 0);
        fr[3]   = mk(519, 0);
        fr[511] = mk(0, -520);
        send_frame(FFT_LEN, -1);

        // Early tlast, then a good frame.
        clear_frame();
        fr[200] = mk(5000, 0);
        send_frame(501, -1);
        send_frame(FFT_LEN, -1);

        // Full-scale negative components.
        clear_frame();
        fr[300] = mk(-32768, -32768);
        send_frame(FFT_LEN, -1);

        // Single-beat frame.
        clear_frame();
        fr[0] = mk(30000, 0);
        send_frame(1, -1);

        // Reset in mid-frame, then a clean frame.
        clear_frame();
        fr[40] = mk(7000, 1000);
        send_frame(FFT_LEN, 600);
        send_frame(FFT_LEN, -1);

        // Randomized frames, including over- and under-length ones.
        for (int r = 0; r < 6; r++) begin
            int len;
            clear_frame();
            for (int b = 0; b < 1100; b++) begin
                if (b >= FFT_LEN / 2 || b < MIN_BIN)
                    fr[b] = mk(int'($urandom_range(0, 20000)) - 10000, int'($urandom_range(0, 20000)) - 10000);
                else
                    fr[b] = mk(int'($urandom_range(0, 700)) - 350, int'($urandom_range(0, 500)) - 250);
            end
            len = (r == 2) ? FFT_LEN + 1 : (r == 4) ? FFT_LEN - 1 : FFT_LEN;
            send_frame(len, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
